// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches, tags each with its pc and
// buffers the returned instructions for decode. A redirect flushes everything and refetches.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   pending_q, pending_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   tag_wr_q, tag_rd_q, q_wr_q, q_rd_q;
  logic [31:0]     tag_mem_q [DEPTH];
  logic [31:0]     q_pc_q    [DEPTH];
  logic [31:0]     q_instr_q [DEPTH];

  logic            req_fire, rsp_ok, rsp_acc, pop, redir_en;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   outstanding;

  // Handshakes: a request transfers when imem_req_valid & imem_req_ready at a rising edge;
  // responses have no back-pressure (imem_rsp_valid alone transfers); decode consumes on
  // out_valid & out_ready.
  assign occupancy      = {1'b0, pending_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == ST_FETCH) && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign out_valid      = (count_q != '0);
  assign pop            = out_valid & out_ready;
  assign redir_en       = redirect && (state_q != ST_IDLE);
  // Only one of pending/drop is non-zero at a time: pending in FETCH, drop in FLUSH.
  assign outstanding    = pending_q + drop_q;
  assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
  assign out_pc         = q_pc_q[q_rd_q];
  assign out_instr      = q_instr_q[q_rd_q];
  assign dbg_state      = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rsp_acc    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        rsp_acc   = imem_rsp_valid && (pending_q != '0);
        pending_d = pending_q + CW'(req_fire) - CW'(rsp_acc);
        count_d   = count_q + CW'(rsp_acc) - CW'(pop);
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      end
      ST_FLUSH: begin
        if (rsp_ok) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Redirect overrides everything; a request accepted this cycle is still owed a response.
    if (redir_en) begin
      rsp_acc    = 1'b0;
      fetch_pc_d = redirect_pc;
      pending_d  = '0;
      count_d    = '0;
      drop_d     = outstanding + CW'(req_fire) - CW'(rsp_ok);
      state_d    = (drop_d == '0) ? ST_FETCH : ST_FLUSH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      if (redir_en) begin
        tag_wr_q <= '0;
        tag_rd_q <= '0;
        q_wr_q   <= '0;
        q_rd_q   <= '0;
      end else begin
        if (req_fire) tag_wr_q <= tag_wr_q + AW'(1);
        if (rsp_acc) begin
          tag_rd_q <= tag_rd_q + AW'(1);
          q_wr_q   <= q_wr_q + AW'(1);
        end
        if (pop) q_rd_q <= q_rd_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
  end

  // Queue storage is reset so out_instr/out_pc read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else if (rsp_acc) begin
      q_pc_q[q_wr_q]    <= tag_mem_q[tag_rd_q];
      q_instr_q[q_wr_q] <= imem_rsp_data;
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (pending_q == '0) && (drop_q == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: a memory model answers requests in order, and a
// monitor compares every fetch, every delivered instruction and the valid flags against a pc-stream model.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_instr, out_pc;
  logic        out_ready = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory and reference-model state (owned by the monitor).
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail, req_exp_pc;
  int cyc = 0, since_reset = 0, cur_epoch = 0, cur_out = 0, stale_out = 0, occ = 0;
  int fires_since_reset = 0, first_req_cyc = -1, first_out_cyc = -1;

  // Stimulus knobs (owned by the driver).
  int ready_pct = 100, oready_pct = 100, redir_pm = 0, lat_min = 1, lat_max = 1;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic extend_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_tail);
      exp_tail += 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_tail   = pc;
    req_exp_pc = pc;
    extend_exp(64);
  endtask

  // Monitor: samples the settled values that the coming rising edge will act on.
  initial begin
    logic        exp_rv;
    logic [31:0] e;
    mreq_t       m;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        mem_q.delete();
        cur_out = 0; stale_out = 0; occ = 0; cur_epoch = 0; since_reset = 0;
        fires_since_reset = 0; first_req_cyc = -1; first_out_cyc = -1;
        model_restart(RESET_PC);
      end else begin
        exp_rv = (since_reset >= 1) && (stale_out == 0) && ((cur_out + occ) < DEPTH);
        check32("out_valid", 32'(out_valid), 32'(occ != 0));
        check32("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (out_valid && out_ready) begin
          if (first_out_cyc < 0) first_out_cyc = since_reset;
          e = exp_q.pop_front();
          check32("out_pc", out_pc, e);
          check32("out_instr", out_instr, mem_word(e));
          if (occ > 0) occ--;
          if (exp_q.size() < 8) extend_exp(64);
        end
        if (imem_req_valid && imem_req_ready) begin
          check32("req_addr", imem_req_addr, req_exp_pc);
          req_exp_pc += 32'd4;
          mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min),
                            epoch: cur_epoch});
          cur_out++;
          fires_since_reset++;
          if (first_req_cyc < 0) first_req_cyc = since_reset;
        end
        if (imem_rsp_valid && mem_q.size() > 0) begin
          m = mem_q.pop_front();
          if (m.epoch == cur_epoch) begin
            cur_out--;
            if (!redirect) occ++;
          end else begin
            stale_out--;
          end
        end
        if (redirect) begin
          stale_out += cur_out;
          cur_out = 0;
          cur_epoch++;
          occ = 0;
          model_restart(redirect_pc);
        end
        since_reset++;
      end
      cyc++;
    end
  end

  // Driver: one call drives the inputs for one clock cycle.
  task automatic step();
    @(negedge clk);
    reset          = 1'b0;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    out_ready      = ($urandom_range(99) < oready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect = 1'b0;
    if (since_reset >= 1) begin
      if (force_redir) begin
        redirect    = 1'b1;
        redirect_pc = force_pc;
        force_redir = 1'b0;
      end else if ($urandom_range(999) < redir_pm) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                               : ($urandom & 32'hFFFF_FFFC);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic check_now);
    @(negedge clk);
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    if (check_now) begin
      #1;
      check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check32("rst_out_valid", 32'(out_valid), 32'd0);
      check32("rst_out_instr", out_instr, 32'd0);
      check32("rst_out_pc", out_pc, 32'd0);
      check32("rst_req_addr", imem_req_addr, RESET_PC);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset values.
    @(negedge clk);
    #1;
    check32("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check32("reset_out_valid", 32'(out_valid), 32'd0);
    check32("reset_out_instr", out_instr, 32'd0);
    check32("reset_out_pc", out_pc, 32'd0);
    check32("reset_req_addr", imem_req_addr, RESET_PC);

    // Streaming at full rate: first instruction two cycles after the first request.
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0;
    run(12);
    check32("first_out_latency", 32'(first_out_cyc - first_req_cyc), 32'd2);

    // Decode stalled: the queue fills with exactly DEPTH requests.
    do_reset(1'b0);
    oready_pct = 0;
    run(12);
    #4;
    check32("full_req_count", 32'(fires_since_reset), 32'(DEPTH));
    check32("full_out_valid", 32'(out_valid), 32'd1);
    oready_pct = 100;
    step();
    oready_pct = 0;
    run(3);
    #4;
    check32("after_pop_req_count", 32'(fires_since_reset), 32'(DEPTH + 1));

    // Memory not ready: address held.
    do_reset(1'b0);
    ready_pct = 0; oready_pct = 100;
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      check32("held_addr", imem_req_addr, RESET_PC);
    end
    ready_pct = 100;
    run(6);

    // Redirect with three requests in flight.
    do_reset(1'b0);
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 20 && fires_since_reset < 3; i++) begin
      step();
      #4;
    end
    check32("inflight_before_redirect", 32'(fires_since_reset), 32'd3);
    ready_pct = 0; force_redir = 1'b1; force_pc = 32'h100;
    step();
    ready_pct = 100;
    run(25);

    // Redirect while a request and a response fire together with one pending.
    lat_min = 1; lat_max = 1;
    run(8);
    force_redir = 1'b1; force_pc = 32'h200;
    run(12);

    // Address wrap, then reset in the middle of the burst.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    run(6);
    do_reset(1'b1);

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 30; blk++) begin
      ready_pct  = $urandom_range(100, 30);
      oready_pct = $urandom_range(100, 20);
      lat_min    = $urandom_range(3, 1);
      lat_max    = lat_min + $urandom_range(6, 0);
      redir_pm   = $urandom_range(40, 0);
      run(100);
      if (blk % 10 == 9) do_reset(1'b1);
    end
    redir_pm = 0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
